vga_frame_painter: RTL and testbench

Parametrised pixel-clock-domain VGA scan-out engine. It generates its own sync timing, fetches packed pixels from a framebuffer RAM through a fixed-latency read port, and drives registered RGB/sync/blank to the video DAC. The image window is configurable in size and packing, and can be scaled at runtime by 1x, 2x or 4x. Pixels are shown as grayscale or RGB332. Optional border lines are drawn along the image's right and bottom edges. The block sits between the clock divider and the DAC, replacing fixed 256x256 grayscale painting.

---
 rtl/vga_frame_painter.sv | 272 +++++++++++++++++++++++++++
 tb/tb_vga_frame_painter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_painter.sv
// VGA scan-out engine: generates sync timing, fetches packed pixels from a
// fixed-latency framebuffer port and drives registered RGB/sync/blank.
// Row-base and column-word counters replace any multiply/divide in the
// address path.
module vga_frame_painter #(
    parameter int          HACTIVE      = 640,
    parameter int          HFP          = 16,
    parameter int          HSYN         = 96,
    parameter int          HBP          = 48,
    parameter int          VACTIVE      = 480,
    parameter int          VFP          = 10,
    parameter int          VSYN         = 2,
    parameter int          VBP          = 33,
    parameter int          IMG_W        = 256,
    parameter int          IMG_H        = 256,
    parameter int          PIX_BITS     = 8,
    parameter int          PIX_PER_WORD = 2,
    parameter int          ADDR_W       = 14,
    parameter int          MEM_LAT      = 1,
    parameter logic [23:0] BG_RGB       = 24'hFFFFFF,
    parameter logic [23:0] BORDER_RGB   = 24'h00FF00,
    localparam int         DATA_W       = PIX_BITS * PIX_PER_WORD
) (
    input  logic              o_clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [1:0]        scale_log2,
    input  logic              mode,
    input  logic              border_en,
    input  logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              o_hs,
    output logic              o_vs,
    output logic              o_blank,
    output logic              o_sync,
    output logic              frame_start
);

    localparam int HTOTAL = HSYN + HBP + HACTIVE + HFP;
    localparam int VTOTAL = VSYN + VBP + VACTIVE + VFP;
    localparam int CW     = 16;
    localparam int LW     = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    localparam logic [CW-1:0]     H_SYNC    = CW'(HSYN);
    localparam logic [CW-1:0]     H_START   = CW'(HSYN + HBP);
    localparam logic [CW-1:0]     H_END     = CW'(HSYN + HBP + HACTIVE);
    localparam logic [CW-1:0]     H_LAST    = CW'(HTOTAL - 1);
    localparam logic [CW-1:0]     V_SYNC    = CW'(VSYN);
    localparam logic [CW-1:0]     V_START   = CW'(VSYN + VBP);
    localparam logic [CW-1:0]     V_END     = CW'(VSYN + VBP + VACTIVE);
    localparam logic [CW-1:0]     V_LAST    = CW'(VTOTAL - 1);
    localparam logic [CW-1:0]     IMG_WC    = CW'(IMG_W);
    localparam logic [CW-1:0]     IMG_HC    = CW'(IMG_H);
    localparam logic [ADDR_W-1:0] ROW_WORDS = ADDR_W'(IMG_W / PIX_PER_WORD);
    localparam logic [LW-1:0]     LANE_LAST = LW'(PIX_PER_WORD - 1);
    localparam logic              RGB_OK    = (PIX_BITS == 8);

    typedef enum logic [1:0] {
        REG_BLANK  = 2'd0,
        REG_IMAGE  = 2'd1,
        REG_BORDER = 2'd2,
        REG_BG     = 2'd3
    } region_t;

    // Everything the output stage needs, carried alongside the memory request.
    // An all-zero tag decodes as blanked with syncs inactive.
    typedef struct packed {
        region_t         region;
        logic [LW-1:0]   lane;
        logic            rgb_mode;
        logic            hsync;
        logic            vsync;
        logic            fs;
    } tag_t;

    logic [CW-1:0]     hcnt, vcnt;
    logic [ADDR_W-1:0] sh_base;
    logic [1:0]        sh_scale;
    logic              sh_mode, sh_border;

    logic [1:0]        xsub, ysub;
    logic [CW-1:0]     px, py;
    logic [LW-1:0]     lane;
    logic [ADDR_W-1:0] colw, row_base;

    logic              h_wrap, v_wrap, h_act, v_act, act;
    logic [CW-1:0]     sx, sy;
    logic [1:0]        sub_last;
    region_t           region;
    tag_t              tag_in, tag_out;
    tag_t              pipe [0:MEM_LAT];

    logic [PIX_BITS-1:0] pix;
    logic [7:0]          p8, gray;
    logic [23:0]         pix_rgb;

    // Timing decode of the current counter state
    always_comb begin
        h_wrap   = (hcnt == H_LAST);
        v_wrap   = (vcnt == V_LAST);
        h_act    = (hcnt >= H_START) && (hcnt < H_END);
        v_act    = (vcnt >= V_START) && (vcnt < V_END);
        act      = h_act && v_act;
        sx       = hcnt - H_START;
        sy       = vcnt - V_START;
        sub_last = 2'((3'd1 << sh_scale) - 3'd1);
    end

    // Free-running raster counters
    always_ff @(posedge o_clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_wrap) begin
            hcnt <= '0;
            vcnt <= v_wrap ? '0 : vcnt + CW'(1);
        end else begin
            hcnt <= hcnt + CW'(1);
        end
    end

    // Frame-level shadow of the runtime controls, captured at raster origin
    always_ff @(posedge o_clk or posedge rst) begin
        if (rst) begin
            sh_base   <= '0;
            sh_scale  <= '0;
            sh_mode   <= 1'b0;
            sh_border <= 1'b0;
        end else if (hcnt == '0 && vcnt == '0) begin
            sh_base   <= base_addr;
            sh_scale  <= (scale_log2 == 2'd3) ? 2'd2 : scale_log2;
            sh_mode   <= mode & RGB_OK;
            sh_border <= border_en;
        end
    end

    // Horizontal source-pixel stepping: held at zero outside the active span
    always_ff @(posedge o_clk or posedge rst) begin
        if (rst) begin
            xsub <= '0;
            px   <= '0;
            lane <= '0;
            colw <= '0;
        end else if (!h_act) begin
            xsub <= '0;
            px   <= '0;
            lane <= '0;
            colw <= '0;
        end else if (xsub == sub_last) begin
            xsub <= '0;
            px   <= px + CW'(1);
            if (lane == LANE_LAST) begin
                lane <= '0;
                colw <= colw + ADDR_W'(1);
            end else begin
                lane <= lane + LW'(1);
            end
        end else begin
            xsub <= xsub + 2'd1;
        end
    end

    // Vertical source-line stepping; row base reloads from the shadow between frames
    always_ff @(posedge o_clk or posedge rst) begin
        if (rst) begin
            ysub     <= '0;
            py       <= '0;
            row_base <= '0;
        end else if (!v_act) begin
            ysub     <= '0;
            py       <= '0;
            row_base <= sh_base;
        end else if (h_wrap) begin
            if (ysub == sub_last) begin
                ysub     <= '0;
                py       <= py + CW'(1);
                row_base <= row_base + ROW_WORDS;
            end else begin
                ysub <= ysub + 2'd1;
            end
        end
    end

    // Region classification and request tag for the current raster position
    always_comb begin
        if (!act) begin
            region = REG_BLANK;
        end else if (px < IMG_WC && py < IMG_HC) begin
            region = REG_IMAGE;
        end else if (sh_border &&
                     ((sx == (IMG_WC << sh_scale) && py <= IMG_HC) ||
                      (sy == (IMG_HC << sh_scale) && px <= IMG_WC))) begin
            region = REG_BORDER;
        end else begin
            region = REG_BG;
        end
        tag_in          = '0;
        tag_in.region   = region;
        tag_in.lane     = lane;
        tag_in.rgb_mode = sh_mode;
        tag_in.hsync    = (hcnt < H_SYNC);
        tag_in.vsync    = (vcnt < V_SYNC);
        tag_in.fs       = (hcnt == H_START) && (vcnt == V_START);
    end

    // Request stage plus tag delay line matching the memory latency
    always_ff @(posedge o_clk or posedge rst) begin
        if (rst) begin
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            for (int unsigned i = 0; i <= MEM_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            if (region == REG_IMAGE) begin
                mem_addr <= row_base + colw;
            end
            mem_rd  <= (region == REG_IMAGE);
            pipe[0] <= tag_in;
            for (int unsigned i = 1; i <= MEM_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Lane extraction and colour expansion of the returned word
    always_comb begin
        tag_out = pipe[MEM_LAT];
        pix     = PIX_BITS'(mem_data >> (32'(tag_out.lane) * PIX_BITS));
        p8      = 8'(pix);
        gray    = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            gray[7-i] = pix[PIX_BITS - 1 - (i % PIX_BITS)];
        end
        if (tag_out.rgb_mode) begin
            pix_rgb = {p8[7:5], p8[7:5], p8[7:6],
                       p8[4:2], p8[4:2], p8[4:3],
                       p8[1:0], p8[1:0], p8[1:0], p8[1:0]};
        end else begin
            pix_rgb = {gray, gray, gray};
        end
    end

    // Registered video outputs; sync polarity inverted so a cleared tag idles high
    always_ff @(posedge o_clk or posedge rst) begin
        if (rst) begin
            {r, g, b}   <= '0;
            o_hs        <= 1'b1;
            o_vs        <= 1'b1;
            o_blank     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            unique case (tag_out.region)
                REG_BLANK:  {r, g, b} <= '0;
                REG_IMAGE:  {r, g, b} <= pix_rgb;
                REG_BORDER: {r, g, b} <= BORDER_RGB;
                REG_BG:     {r, g, b} <= BG_RGB;
            endcase
            o_blank     <= (tag_out.region != REG_BLANK);
            o_hs        <= ~tag_out.hsync;
            o_vs        <= ~tag_out.vsync;
            frame_start <= tag_out.fs;
        end
    end

    assign o_sync = 1'b0;

endmodule

// File: tb/tb_vga_frame_painter.sv
// Bench for vga_frame_painter: two small instances (8-bit pixels with one
// cycle of memory latency, 4-bit pixels with three) driven by shared random
// controls and compared every cycle to a raster model computed from the
// cycle count since reset release.
module tb_vga_frame_painter;

    localparam int HACT = 16, HFP = 2, HSYN = 2, HBP = 2;
    localparam int VACT = 8,  VFP = 2, VSYN = 2, VBP = 2;
    localparam int IMG_W = 8, IMG_H = 4, PPW = 2, AW = 14;
    localparam int HT = HSYN + HBP + HACT + HFP;
    localparam int VT = VSYN + VBP + VACT + VFP;
    localparam int FR = HT * VT;
    localparam int LA = 3;
    localparam int LB = 5;

    logic          clk;
    logic          rst;
    logic [AW-1:0] base_addr;
    logic [1:0]    scale_log2;
    logic          mode;
    logic          border_en;

    logic [15:0]   mem_data_a;
    logic [AW-1:0] mem_addr_a;
    logic          mem_rd_a, hs_a, vs_a, blank_a, sync_a, fs_a;
    logic [7:0]    r_a, g_a, b_a;

    logic [7:0]    mem_data_b;
    logic [AW-1:0] mem_addr_b;
    logic          mem_rd_b, hs_b, vs_b, blank_b, sync_b, fs_b;
    logic [7:0]    r_b, g_b, b_b;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int exp_addr = 0;
    int cfg_base [64];
    int cfg_scale [64];
    int cfg_mode [64];
    int cfg_border [64];

    vga_frame_painter #(
        .HACTIVE(HACT), .HFP(HFP), .HSYN(HSYN), .HBP(HBP),
        .VACTIVE(VACT), .VFP(VFP), .VSYN(VSYN), .VBP(VBP),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_BITS(8), .PIX_PER_WORD(PPW),
        .ADDR_W(AW), .MEM_LAT(1)
    ) dut_a (
        .o_clk(clk), .rst(rst), .base_addr(base_addr), .scale_log2(scale_log2),
        .mode(mode), .border_en(border_en), .mem_data(mem_data_a),
        .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .r(r_a), .g(g_a), .b(b_a),
        .o_hs(hs_a), .o_vs(vs_a), .o_blank(blank_a), .o_sync(sync_a),
        .frame_start(fs_a)
    );

    vga_frame_painter #(
        .HACTIVE(HACT), .HFP(HFP), .HSYN(HSYN), .HBP(HBP),
        .VACTIVE(VACT), .VFP(VFP), .VSYN(VSYN), .VBP(VBP),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_BITS(4), .PIX_PER_WORD(PPW),
        .ADDR_W(AW), .MEM_LAT(3)
    ) dut_b (
        .o_clk(clk), .rst(rst), .base_addr(base_addr), .scale_log2(scale_log2),
        .mode(mode), .border_en(border_en), .mem_data(mem_data_b),
        .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .r(r_b), .g(g_b), .b(b_b),
        .o_hs(hs_b), .o_vs(vs_b), .o_blank(blank_b), .o_sync(sync_b),
        .frame_start(fs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer contents: word n of A holds pixels 2n, 2n+1; B is a hash
    function automatic logic [15:0] ram_a(input logic [AW-1:0] a);
        int n;
        n = int'(a);
        return {8'(2 * n + 1), 8'(2 * n)};
    endfunction

    function automatic logic [7:0] ram_b(input logic [AW-1:0] a);
        return 8'(int'(a) * 29 + 7);
    endfunction

    // RAM A answers one cycle after the address, RAM B three cycles after
    logic [7:0] rb_q [3];
    always @(posedge clk) begin
        mem_data_a <= ram_a(mem_addr_a);
        rb_q[0]    <= ram_b(mem_addr_b);
        rb_q[1]    <= rb_q[0];
        rb_q[2]    <= rb_q[1];
    end
    assign mem_data_b = rb_q[2];

    // Raster model: region 0 blank, 1 image, 2 border, 3 background
    function automatic void classify(input int t, output int region,
                                     output int addr, output int lane);
        int h, v, f, s, sx, sy, px, py;
        region = 0;
        addr   = 0;
        lane   = 0;
        h = t % HT;
        v = (t / HT) % VT;
        f = (t / FR) % 64;
        if (h < HSYN + HBP || h >= HSYN + HBP + HACT) return;
        if (v < VSYN + VBP || v >= VSYN + VBP + VACT) return;
        s  = (cfg_scale[f] == 3) ? 2 : cfg_scale[f];
        sx = h - (HSYN + HBP);
        sy = v - (VSYN + VBP);
        px = sx / (1 << s);
        py = sy / (1 << s);
        if (px < IMG_W && py < IMG_H) begin
            region = 1;
            addr   = (cfg_base[f] + py * (IMG_W / PPW) + px / PPW) % (1 << AW);
            lane   = px % PPW;
        end else if (cfg_border[f] != 0 &&
                     ((sx == IMG_W * (1 << s) && py <= IMG_H) ||
                      (sy == IMG_H * (1 << s) && px <= IMG_W))) begin
            region = 2;
        end else begin
            region = 3;
        end
    endfunction

    function automatic logic [23:0] exp_rgb(input int which, input int t);
        int region, addr, lane, p, w;
        if (t < 0) return 24'h0;
        classify(t, region, addr, lane);
        case (region)
            0: return 24'h000000;
            2: return 24'h00FF00;
            3: return 24'hFFFFFF;
            default: begin
                if (which == 0) begin
                    p = (2 * addr + lane) % 256;
                    if (cfg_mode[(t / FR) % 64] != 0)
                        return {8'(((p >> 5) * 255 + 3) / 7),
                                8'((((p >> 2) % 8) * 255 + 3) / 7),
                                8'((p % 4) * 85)};
                    return {8'(p), 8'(p), 8'(p)};
                end
                w = (addr * 29 + 7) % 256;
                p = ((w >> (4 * lane)) % 16) * 17;
                return {8'(p), 8'(p), 8'(p)};
            end
        endcase
    endfunction

    function automatic logic exp_hs(input int t);
        return (t < 0) ? 1'b1 : ((t % HT) >= HSYN);
    endfunction

    function automatic logic exp_vs(input int t);
        return (t < 0) ? 1'b1 : (((t / HT) % VT) >= VSYN);
    endfunction

    function automatic logic exp_blank(input int t);
        int region, addr, lane;
        if (t < 0) return 1'b0;
        classify(t, region, addr, lane);
        return (region != 0);
    endfunction

    function automatic logic exp_fs(input int t);
        if (t < 0) return 1'b0;
        return ((t % HT) == HSYN + HBP) && (((t / HT) % VT) == VSYN + VBP);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic check_all();
        int ta, tb, tm, region, addr, lane;
        logic rd_exp;
        ta = cyc - LA;
        tb = cyc - LB;
        tm = cyc - 1;
        rd_exp = 1'b0;
        if (tm >= 0) begin
            classify(tm, region, addr, lane);
            if (region == 1) begin
                rd_exp   = 1'b1;
                exp_addr = addr;
            end
        end
        chk("mem_rd_a",   mem_rd_a,          rd_exp);
        chk("mem_addr_a", mem_addr_a,        exp_addr);
        chk("rgb_a",      {r_a, g_a, b_a},   exp_rgb(0, ta));
        chk("hs_a",       hs_a,              exp_hs(ta));
        chk("vs_a",       vs_a,              exp_vs(ta));
        chk("blank_a",    blank_a,           exp_blank(ta));
        chk("fs_a",       fs_a,              exp_fs(ta));
        chk("sync_a",     sync_a,            1'b0);
        chk("mem_rd_b",   mem_rd_b,          rd_exp);
        chk("mem_addr_b", mem_addr_b,        exp_addr);
        chk("rgb_b",      {r_b, g_b, b_b},   exp_rgb(1, tb));
        chk("hs_b",       hs_b,              exp_hs(tb));
        chk("vs_b",       vs_b,              exp_vs(tb));
        chk("blank_b",    blank_b,           exp_blank(tb));
        chk("fs_b",       fs_b,              exp_fs(tb));
        chk("sync_b",     sync_b,            1'b0);
    endtask

    // One clock: record controls seen at raster origin, then check after the edge
    task automatic step();
        if (!rst && (cyc % FR) == 0) begin
            cfg_base[(cyc / FR) % 64]   = int'(base_addr);
            cfg_scale[(cyc / FR) % 64]  = int'(scale_log2);
            cfg_mode[(cyc / FR) % 64]   = int'(mode);
            cfg_border[(cyc / FR) % 64] = int'(border_en);
        end
        @(posedge clk);
        #1;
        if (!rst) cyc++;
        check_all();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic randomize_ctrl();
        base_addr  = AW'($urandom);
        scale_log2 = 2'($urandom_range(0, 3));
        mode       = 1'($urandom_range(0, 1));
        border_en  = 1'($urandom_range(0, 1));
    endtask

    // After reset release, both first frame_start pulses at their exact latency
    task automatic check_fs_latency();
        while (fs_a !== 1'b1 && cyc < 2 * FR) step();
        chk("fs_latency_a", cyc, LA + (VSYN + VBP) * HT + HSYN + HBP);
        while (fs_b !== 1'b1 && cyc < 2 * FR) step();
        chk("fs_latency_b", cyc, LB + (VSYN + VBP) * HT + HSYN + HBP);
    endtask

    initial begin
        rst        = 1'b1;
        base_addr  = '0;
        scale_log2 = 2'd0;
        mode       = 1'b0;
        border_en  = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check_fs_latency();

        // base change mid-frame: frame 0 keeps reading from 0, frame 1 from 0x40
        run_to(150);
        base_addr = 14'h0040;
        // 2x scale, RGB332, base at the top of the address space
        run_to(FR + 150);
        scale_log2 = 2'd1;
        mode       = 1'b1;
        base_addr  = 14'h3FFF;
        // 4x scale clips the image; base close to the wrap point
        run_to(2 * FR + 150);
        scale_log2 = 2'd2;
        mode       = 1'b0;
        base_addr  = 14'h3FFC;
        // scale code 3 behaves as 4x, border disabled
        run_to(3 * FR + 150);
        scale_log2 = 2'd3;
        mode       = 1'b1;
        border_en  = 1'b0;
        base_addr  = AW'($urandom);
        run_to(4 * FR + 150);
        scale_log2 = 2'd0;
        border_en  = 1'b1;
        base_addr  = AW'($urandom);
        for (int k = 0; k < 5; k++) begin
            run_to((5 + k) * FR + $urandom_range(20, 280));
            randomize_ctrl();
        end

        // asynchronous reset in the middle of an active line
        run_to(10 * FR + 5 * HT + 10);
        rst      = 1'b1;
        cyc      = 0;
        exp_addr = 0;
        #1;
        check_all();
        repeat (3) step();
        rst = 1'b0;
        check_fs_latency();
        for (int k = 0; k < 2; k++) begin
            run_to(k * FR + $urandom_range(150, 290));
            randomize_ctrl();
        end
        run_to(3 * FR);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
